// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: forward-select encoding and tag-entry field layout shared by the hazard unit
package hazard_pkg;
  localparam int FWD_RF = 0;
  localparam int TAG_AVAIL = 0;
  localparam int TAG_WE = 1;
  localparam int TAG_RD = 2;
  function automatic int tag_w(int aw);
    return aw + 3;
  endfunction
  function automatic int fwd_code(int stage);
    return stage + 1;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side request and hazard-unit response bundle
interface hazard_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW = 5,
  parameter int SEL_W = 2
);
  logic hold;
  logic flush;
  logic id_valid;
  logic [NUM_SRC-1:0] id_src_used;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rd;
  logic id_we;
  logic id_is_load;
  logic id_is_long;
  logic long_done;
  logic [REG_AW-1:0] long_rd;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic stall;
  logic long_busy;
  modport master (
    output hold, flush, id_valid, id_src_used, id_rs, id_rd, id_we, id_is_load, id_is_long, long_done, long_rd,
    input fwd_sel, stall, long_busy
  );
  modport slave (
    input hold, flush, id_valid, id_src_used, id_rs, id_rd, id_we, id_is_load, id_is_long, long_done, long_rd,
    output fwd_sel, stall, long_busy
  );
endinterface

// File: rtl/hazard_scoreboard_fwd_src_match.sv
// fwd_src_match: youngest-wins match of one source register against the tag pipeline
module fwd_src_match #(
  parameter int FWD_STAGES = 3,
  parameter int REG_AW = 5,
  parameter int SEL_W = 2
) (
  input  logic                         used_i,
  input  logic [REG_AW-1:0]            rs_i,
  input  logic [FWD_STAGES-1:0]        ent_valid_i,
  input  logic [FWD_STAGES*REG_AW-1:0] ent_rd_i,
  input  logic [FWD_STAGES-1:0]        ent_avail_i,
  output logic                         hit_o,
  output logic [SEL_W-1:0]             stage_o,
  output logic                         not_ready_o
);
  always_comb begin
    hit_o = 1'b0;
    stage_o = '0;
    not_ready_o = 1'b0;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      if (used_i && |rs_i && ent_valid_i[s] && ent_rd_i[s*REG_AW +: REG_AW] == rs_i) begin
        hit_o = 1'b1;
        stage_o = SEL_W'(s);
        not_ready_o = s < int'(ent_avail_i[s]);
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding select and stall generation beside decode, with long-op scoreboard
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int FWD_STAGES = 3,
  parameter int REG_AW = 5,
  parameter int SEL_W = 2
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  localparam int TW = tag_w(REG_AW);
  logic [TW-1:0] tag_q [FWD_STAGES];
  logic [TW-1:0] tag_d;
  logic [2**REG_AW-1:0] pending_q, pending_d;
  logic long_busy_q, long_busy_d;
  logic [FWD_STAGES-1:0] ent_valid, ent_avail;
  logic [FWD_STAGES*REG_AW-1:0] ent_rd;
  logic [NUM_SRC-1:0] src_hit, src_nr, src_raw;
  logic [NUM_SRC*SEL_W-1:0] src_stage, fwd_sel;
  logic stall, issue, issue_long;
  for (genvar s = 0; s < FWD_STAGES; s++) begin : g_ent
    assign ent_valid[s] = tag_q[s][TW-1] & tag_q[s][TAG_WE];
    assign ent_rd[s*REG_AW +: REG_AW] = tag_q[s][TAG_RD +: REG_AW];
    assign ent_avail[s] = tag_q[s][TAG_AVAIL];
  end
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_match #(.FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_match (
      .used_i(bus.id_src_used[k]),
      .rs_i(bus.id_rs[k*REG_AW +: REG_AW]),
      .ent_valid_i(ent_valid),
      .ent_rd_i(ent_rd),
      .ent_avail_i(ent_avail),
      .hit_o(src_hit[k]),
      .stage_o(src_stage[k*SEL_W +: SEL_W]),
      .not_ready_o(src_nr[k])
    );
    assign src_raw[k] = bus.id_src_used[k] & pending_q[bus.id_rs[k*REG_AW +: REG_AW]];
    assign fwd_sel[k*SEL_W +: SEL_W] = (src_hit[k] & ~src_nr[k]) ?
      SEL_W'(fwd_code(int'(src_stage[k*SEL_W +: SEL_W]))) : SEL_W'(FWD_RF);
  end
  assign stall = bus.id_valid & (|(src_hit & src_nr) | |src_raw |
                 (bus.id_we & pending_q[bus.id_rd]) | (bus.id_is_long & long_busy_q));
  assign issue = bus.id_valid & ~stall & ~bus.flush;
  assign issue_long = issue & bus.id_is_long & ~bus.hold;
  assign bus.fwd_sel = fwd_sel;
  assign bus.stall = stall;
  assign bus.long_busy = long_busy_q;
  always_comb begin
    tag_d = '0;
    tag_d[TW-1] = issue & bus.id_we & |bus.id_rd & ~bus.id_is_long;
    tag_d[TAG_RD +: REG_AW] = bus.id_rd;
    tag_d[TAG_WE] = bus.id_we;
    tag_d[TAG_AVAIL] = bus.id_is_load;
    pending_d = pending_q;
    if (bus.long_done) pending_d[bus.long_rd] = 1'b0;
    if (issue_long & bus.id_we & |bus.id_rd) pending_d[bus.id_rd] = 1'b1;
    long_busy_d = issue_long | (long_busy_q & ~bus.long_done);
  end
  // Flush kills the ID instruction and the current EX entry, which would otherwise move to MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      long_busy_q <= 1'b0;
      for (int s = 0; s < FWD_STAGES; s++) tag_q[s] <= '0;
    end else begin
      pending_q <= pending_d;
      long_busy_q <= long_busy_d;
      if (!bus.hold) begin
        tag_q[0] <= tag_d;
        for (int s = 1; s < FWD_STAGES; s++) tag_q[s] <= (s == 1 && bus.flush) ? '0 : tag_q[s-1];
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked by a queue-fed monitor
module tb_hazard_scoreboard;
  localparam int NS = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.NUM_SRC(2), .REG_AW(5), .SEL_W(2)) bus ();
  hazard_scoreboard #(.NUM_SRC(2), .FWD_STAGES(NS), .REG_AW(5), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {string nm; bit st; int s0; int s1; bit bz; bit cs;} exp_t;
  typedef struct {bit v; int rd; bit ld;} prod_t;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  prod_t pipe[$];
  bit pend[32];
  bit busy;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (bus.stall !== e.st) begin
        n_fail++;
        $display("FAIL %s stall got %0b want %0b", e.nm, bus.stall, e.st);
      end
      n_chk++;
      if (bus.long_busy !== e.bz) begin
        n_fail++;
        $display("FAIL %s long_busy got %0b want %0b", e.nm, bus.long_busy, e.bz);
      end
      if (e.cs) begin
        n_chk += 2;
        if (bus.fwd_sel[1:0] !== 2'(e.s0)) begin
          n_fail++;
          $display("FAIL %s fwd_sel[0] got %0d want %0d", e.nm, bus.fwd_sel[1:0], e.s0);
        end
        if (bus.fwd_sel[3:2] !== 2'(e.s1)) begin
          n_fail++;
          $display("FAIL %s fwd_sel[1] got %0d want %0d", e.nm, bus.fwd_sel[3:2], e.s1);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic id(input bit v, input bit u0, input int r0, input bit u1, input int r1,
                    input int rd, input bit we, input bit ld, input bit lg);
    bus.id_valid = v;
    bus.id_src_used = {u1, u0};
    bus.id_rs = {5'(r1), 5'(r0)};
    bus.id_rd = 5'(rd);
    bus.id_we = we;
    bus.id_is_load = ld;
    bus.id_is_long = lg;
  endtask
  task automatic step(input string nm, input bit st, input int s0, input int s1, input bit bz, input bit cs);
    exp_q.push_back('{nm, st, s0, s1, bz, cs});
    @(posedge clk);
    #1;
  endtask
  // Reference: a producer list (youngest first) and a set of registers owed by the long unit.
  task automatic model_eval(output bit st, output int s0, output int s1);
    int sel[2];
    bit haz = 0;
    for (int k = 0; k < 2; k++) begin
      int rs = int'(bus.id_rs[k*5 +: 5]);
      sel[k] = 0;
      if (bus.id_src_used[k] && rs != 0) begin
        if (pend[rs]) haz = 1;
        for (int s = 0; s < NS; s++) begin
          if (pipe[s].v && pipe[s].rd == rs) begin
            if (s < int'(pipe[s].ld)) haz = 1;
            else sel[k] = s + 1;
            break;
          end
        end
      end
    end
    if (bus.id_we && pend[bus.id_rd]) haz = 1;
    if (bus.id_is_long && busy) haz = 1;
    st = bus.id_valid && haz;
    s0 = sel[0];
    s1 = sel[1];
  endtask
  task automatic model_edge(input bit st);
    bit iss = bus.id_valid && !st && !bus.flush && !bus.hold;
    if (bus.long_done) pend[bus.long_rd] = 0;
    if (iss && bus.id_is_long) begin
      busy = 1;
      if (bus.id_we && bus.id_rd != 0) pend[bus.id_rd] = 1;
    end else if (bus.long_done) busy = 0;
    if (!bus.hold) begin
      pipe.push_front('{iss && bus.id_we && bus.id_rd != 0 && !bus.id_is_long, int'(bus.id_rd), bus.id_is_load});
      if (bus.flush) pipe[1].v = 0;
      void'(pipe.pop_back());
    end
  endtask
  initial begin
    bit st;
    int s0, s1, lrd;
    bus.hold = 0; bus.flush = 0; bus.long_done = 0; bus.long_rd = '0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 0, 1);
    rst = 0;
    id(1, 0, 0, 0, 0, 5, 1, 0, 0);   step("alu_x5", 0, 0, 0, 0, 1);
    id(1, 1, 5, 0, 0, 10, 1, 0, 0);  step("fwd_ex", 0, 1, 0, 0, 1);
    id(1, 0, 0, 0, 0, 5, 1, 0, 0);   step("alu_x5b", 0, 0, 0, 0, 1);
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);   step("bubble", 0, 0, 0, 0, 0);
    id(1, 1, 5, 1, 10, 0, 0, 0, 0);  step("fwd_mem_wb", 0, 2, 3, 0, 1);
    id(1, 0, 0, 0, 0, 6, 1, 1, 0);   step("load_x6", 0, 0, 0, 0, 1);
    id(1, 0, 0, 1, 6, 11, 1, 0, 0);  step("load_use", 1, 0, 0, 0, 0);
    step("load_fwd", 0, 0, 2, 0, 1);
    id(1, 0, 0, 0, 0, 7, 1, 0, 0);   step("alu_x7a", 0, 0, 0, 0, 1);
    step("alu_x7b", 0, 0, 0, 0, 1);
    id(1, 1, 7, 1, 7, 0, 0, 0, 0);   step("youngest", 0, 1, 1, 0, 1);
    id(1, 0, 0, 0, 0, 0, 1, 0, 0);   step("alu_x0", 0, 0, 0, 0, 1);
    id(1, 1, 0, 1, 0, 0, 0, 0, 0);   step("read_x0", 0, 0, 0, 0, 1);
    id(1, 0, 0, 0, 0, 9, 1, 0, 1);   step("long_x9", 0, 0, 0, 0, 1);
    id(1, 1, 9, 0, 0, 12, 1, 0, 0);  step("raw_1", 1, 0, 0, 1, 0);
    step("raw_2", 1, 0, 0, 1, 0);
    id(1, 0, 0, 0, 0, 13, 1, 0, 1);  step("struct", 1, 0, 0, 1, 0);
    id(1, 1, 9, 0, 0, 12, 1, 0, 0);
    bus.long_done = 1; bus.long_rd = 5'd9;
    step("raw_done", 1, 0, 0, 1, 0);
    bus.long_done = 0;
    step("raw_release", 0, 0, 0, 0, 1);
    id(1, 0, 0, 0, 0, 5, 1, 0, 0);   step("alu_x5c", 0, 0, 0, 0, 1);
    id(1, 1, 5, 0, 0, 0, 0, 0, 0);
    bus.hold = 1;
    for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), 0, 1, 0, 0, 1);
    bus.hold = 0; bus.flush = 1;     step("flush", 0, 1, 0, 0, 1);
    bus.flush = 0;                   step("killed", 0, 0, 0, 0, 1);
    id(1, 0, 0, 0, 0, 9, 1, 0, 1);   step("long_x9b", 0, 0, 0, 0, 1);
    id(1, 0, 0, 0, 0, 6, 1, 1, 0);   step("load_x6b", 0, 0, 0, 1, 1);
    id(1, 1, 9, 1, 6, 14, 1, 0, 0);
    bus.hold = 1;                    step("pre_rst", 1, 0, 0, 1, 0);
    rst = 1;                         step("async_rst", 0, 0, 0, 0, 1);
    bus.hold = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 0;
    pipe = {};
    for (int s = 0; s < NS; s++) pipe.push_back('{0, 0, 0});
    for (int r = 0; r < 32; r++) pend[r] = 0;
    busy = 0;
    lrd = 0;
    for (int i = 0; i < 600; i++) begin
      id($urandom_range(3) != 0, $urandom_range(1), $urandom_range(7), $urandom_range(1), $urandom_range(7),
         $urandom_range(7), $urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(9) == 0);
      bus.hold = $urandom_range(9) == 0;
      bus.flush = $urandom_range(19) == 0;
      bus.long_done = busy && $urandom_range(3) == 0;
      bus.long_rd = 5'(lrd);
      model_eval(st, s0, s1);
      if (bus.id_valid && bus.id_is_long && !st && !bus.flush && !bus.hold) lrd = int'(bus.id_rd);
      exp_q.push_back('{$sformatf("rand%0d", i), st, s0, s1, busy, bus.id_valid && !st});
      @(posedge clk);
      model_edge(st);
      #1;
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
